// File: rtl/jpeg_qnt_feeder.sv
// jpeg_qnt_feeder
//   Front end of the quantizer/rounder. It takes the 8x8 DCT coefficient stream
//   and pairs each coefficient with its divisor from a loadable 64-entry table.
//   The coefficient is converted to sign/magnitude, and the pair is held in a
//   one-entry output register with a valid/ready handshake toward the divider.
//
// Ports
//   clk, rst          single clock; synchronous active-high reset
//   tbl_we/addr/din   divisor table write port (zig-zag index order)
//   in_valid/ready    coefficient handshake; in_coef is signed, in_sob marks index 0
//   out_valid/ready   divider handshake
//   out_dividend      |coef|, unsigned
//   out_sign          1 = coefficient was negative
//   out_divisor       divisor, never 0
//   out_idx, out_eob  index of the pair within the block; eob when index is 63
//   err_zero_div      sticky: a zero table entry was used
//   err_misalign      sticky: in_sob arrived while the index was not 0

module jpeg_qnt_feeder #(
    parameter int COEF_W = 12,
    parameter int QNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_we,
    input  logic [5:0]        tbl_addr,
    input  logic [QNT_W-1:0]  tbl_din,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    input  logic              in_sob,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [COEF_W-1:0] out_dividend,
    output logic              out_sign,
    output logic [QNT_W-1:0]  out_divisor,
    output logic [5:0]        out_idx,
    output logic              out_eob,
    output logic              err_zero_div,
    output logic              err_misalign
);

    logic [QNT_W-1:0]  tbl [64];
    logic [5:0]        idx;

    logic              accept;
    logic [5:0]        beat_idx;
    logic [QNT_W-1:0]  tbl_rd;
    logic              zero_entry;
    logic              neg;
    logic [COEF_W-1:0] mag;

    // The register can take a new pair whenever it is empty or being drained
    // this cycle, which allows one pair per clock with out_ready held high.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        accept     = in_valid && in_ready;
        // in_sob forces the beat onto index 0, so the divisor comes from entry 0.
        beat_idx   = in_sob ? 6'd0 : idx;
        // Combinational read sees the pre-write contents of a same-cycle write.
        tbl_rd     = tbl[beat_idx];
        zero_entry = (tbl_rd == '0);
        neg        = in_coef[COEF_W-1];
        // Most negative value maps to 2^(COEF_W-1), which still fits unsigned.
        mag        = neg ? (~in_coef + {{(COEF_W-1){1'b0}}, 1'b1}) : in_coef;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                tbl[i] <= QNT_W'(1);
            end
            idx          <= '0;
            out_valid    <= 1'b0;
            out_dividend <= '0;
            out_sign     <= 1'b0;
            out_divisor  <= QNT_W'(1);
            out_idx      <= '0;
            out_eob      <= 1'b0;
            err_zero_div <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            if (accept) begin
                out_valid    <= 1'b1;
                out_dividend <= mag;
                // A zero coefficient has a clear sign bit, so it never reports negative.
                out_sign     <= neg;
                out_divisor  <= zero_entry ? QNT_W'(1) : tbl_rd;
                out_idx      <= beat_idx;
                out_eob      <= (beat_idx == 6'd63);
                idx          <= beat_idx + 6'd1;
                if (zero_entry) begin
                    err_zero_div <= 1'b1;
                end
                if (in_sob && (idx != 6'd0)) begin
                    err_misalign <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (tbl_we) begin
                tbl[tbl_addr] <= tbl_din;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_qnt_feeder.sv
// Testbench for jpeg_qnt_feeder: directed scenarios followed by random traffic,
// all checked cycle by cycle against a behavioural model of the held pair.

module tb_jpeg_qnt_feeder;

    localparam int COEF_W = 12;
    localparam int QNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              tbl_we;
    logic [5:0]        tbl_addr;
    logic [QNT_W-1:0]  tbl_din;
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              in_sob;
    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_dividend;
    logic              out_sign;
    logic [QNT_W-1:0]  out_divisor;
    logic [5:0]        out_idx;
    logic              out_eob;
    logic              err_zero_div;
    logic              err_misalign;

    always #5 clk = ~clk;

    jpeg_qnt_feeder #(.COEF_W(COEF_W), .QNT_W(QNT_W)) dut (
        .clk(clk), .rst(rst),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_din(tbl_din),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_sob(in_sob),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dividend(out_dividend), .out_sign(out_sign), .out_divisor(out_divisor),
        .out_idx(out_idx), .out_eob(out_eob),
        .err_zero_div(err_zero_div), .err_misalign(err_misalign)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: table contents, block position and the pair being held.
    int m_tbl [64];
    int m_idx;
    bit m_valid;
    int m_dvd;
    bit m_sign;
    int m_div;
    int m_oidx;
    bit m_zerr;
    bit m_merr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_idx = 0; m_valid = 0; m_dvd = 0; m_sign = 0; m_div = 1; m_oidx = 0;
        m_zerr = 0; m_merr = 0;
    endtask

    // One clock: drive at the falling edge, check in_ready, advance the model,
    // then check every output shortly after the rising edge.
    task automatic step(input logic r, input logic we, input logic [5:0] a,
                        input logic [QNT_W-1:0] din, input logic v, input logic sob,
                        input logic [COEF_W-1:0] coef, input logic ordy);
        int c, k;
        bit acc;
        @(negedge clk);
        rst = r; tbl_we = we; tbl_addr = a; tbl_din = din;
        in_valid = v; in_sob = sob; in_coef = coef; out_ready = ordy;
        #1;
        if (r) begin
            model_reset();
        end else begin
            check("in_ready", in_ready, 32'(!m_valid || ordy));
            acc = v && (!m_valid || ordy);
            if (acc) begin
                k = sob ? 0 : m_idx;
                if (sob && m_idx != 0) m_merr = 1;
                m_div = m_tbl[k];
                if (m_div == 0) begin
                    m_div  = 1;
                    m_zerr = 1;
                end
                c      = int'($signed(coef));
                m_dvd  = (c < 0) ? -c : c;
                m_sign = (c < 0);
                m_oidx = k;
                m_idx  = (k + 1) % 64;
                m_valid = 1;
            end else if (ordy) begin
                m_valid = 0;
            end
            if (we) m_tbl[a] = int'(din);
        end
        @(posedge clk);
        #1;
        check("out_valid",    out_valid,    32'(m_valid));
        check("out_dividend", out_dividend, 32'(m_dvd));
        check("out_sign",     out_sign,     32'(m_sign));
        check("out_divisor",  out_divisor,  32'(m_div));
        check("out_idx",      out_idx,      32'(m_oidx));
        check("out_eob",      out_eob,      32'(m_oidx == 63));
        check("err_zero_div", err_zero_div, 32'(m_zerr));
        check("err_misalign", err_misalign, 32'(m_merr));
    endtask

    task automatic beat(input logic [COEF_W-1:0] coef, input logic sob);
        step(1'b0, 1'b0, 6'd0, '0, 1'b1, sob, coef, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 6'd0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    logic [COEF_W-1:0] rc;
    logic [QNT_W-1:0]  rd;

    initial begin
        rst = 1'b1; tbl_we = 0; tbl_addr = 0; tbl_din = 0;
        in_valid = 0; in_sob = 0; in_coef = 0; out_ready = 0;
        model_reset();

        // Reset state, then a full block plus one beat through the default table.
        do_reset();
        for (int i = 0; i < 65; i++) beat(COEF_W'($urandom), i == 0);

        // Table load k+2, then -5 at index 3 and -2048 at index 4.
        for (int k = 0; k < 64; k++)
            step(1'b0, 1'b1, 6'(k), QNT_W'(k + 2), 1'b0, 1'b0, '0, 1'b1);
        beat(12'sd100, 1'b1);
        beat(12'sd0, 1'b0);
        beat(12'sd7, 1'b0);
        beat(-12'sd5, 1'b0);
        beat(12'h800, 1'b0);
        beat(12'h7FF, 1'b0);

        // Back-pressure: hold out_ready low for 4 cycles with a pending pair.
        beat(12'h123, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0, 12'hABC, 1'b0);
        step(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Write and accept the same index in one cycle: old divisor is used.
        step(1'b0, 1'b1, 6'(m_idx), 8'd77, 1'b1, 1'b0, 12'hF00, 1'b1);

        // Zero entry at index 0, then a block.
        step(1'b0, 1'b1, 6'd0, 8'd0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 64; i++) beat(COEF_W'($urandom), i == 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 6'd0, '0, 1'b0, 1'b0, '0, 1'b1);

        // Start-of-block marker arriving mid-block at index 10.
        for (int i = 0; i < 10; i++) beat(COEF_W'($urandom), i == 0);
        beat(12'hFFF, 1'b1);
        beat(12'h001, 1'b0);

        // Reset mid-block with a pair held, then a block on the reset table.
        beat(12'h055, 1'b0);
        step(1'b0, 1'b0, 6'd0, '0, 1'b1, 1'b0, 12'h066, 1'b0);
        do_reset();
        for (int i = 0; i < 64; i++) beat(COEF_W'($urandom), 1'b0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 9))
                0:       rc = 12'h800;
                1:       rc = 12'h000;
                default: rc = COEF_W'($urandom);
            endcase
            rd = ($urandom_range(0, 3) == 0) ? 8'd0 : QNT_W'($urandom);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 7) == 0, 6'($urandom), rd,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, rc,
                 $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
